// File: rtl/memory_request_arbiter.sv
// memory_request_arbiter
// Two-port round-robin arbiter in front of the DDR2 controller (core clock
// domain). It grants one 128-bit line request at a time, then drives the
// controller's four-phase request (en/rcv) and response (done/ack) handshakes.
// It returns the read line, or a write completion, to the granted port as a
// one-cycle done pulse.
//
// Ports
//   i_clk, i_rst            core clock, asynchronous active-low reset
//   i_pX_req/we/addr/strb/data   requester X (0 = dcache, 1 = icache) request
//   o_pX_done, o_pX_data    requester X completion pulse and read line
//   o_mem_en/we/addr/strb/data   request to controller (payload latched at grant)
//   i_mem_rcv               controller request receipt
//   i_mem_done, i_mem_data  controller response (level until acked) and line
//   o_mem_ack               response acknowledge
//
// Optional feature MEM_ARB_PERF_EN: adds PERF_WIDTH-wide o_rd_count and
// o_wr_count completion counters (wrapping).

module memory_request_arbiter #(
    parameter int unsigned ADDR_WIDTH = 23,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
`ifdef MEM_ARB_PERF_EN
    , parameter int unsigned PERF_WIDTH = 32
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_p0_req,
    input  logic                  i_p0_we,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [STRB_WIDTH-1:0] i_p0_strb,
    input  logic [DATA_WIDTH-1:0] i_p0_data,
    output logic                  o_p0_done,
    output logic [DATA_WIDTH-1:0] o_p0_data,
    input  logic                  i_p1_req,
    input  logic                  i_p1_we,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [STRB_WIDTH-1:0] i_p1_strb,
    input  logic [DATA_WIDTH-1:0] i_p1_data,
    output logic                  o_p1_done,
    output logic [DATA_WIDTH-1:0] o_p1_data,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [STRB_WIDTH-1:0] o_mem_strb,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic                  i_mem_rcv,
    input  logic                  i_mem_done,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_mem_ack
`ifdef MEM_ARB_PERF_EN
    , output logic [PERF_WIDTH-1:0] o_rd_count
    , output logic [PERF_WIDTH-1:0] o_wr_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_RELEASE,
        S_WAIT_DONE,
        S_ACK,
        S_COMPLETE
    } state_t;

    state_t state;
    logic   grant;       // port owning the current transaction
    logic   last_grant;  // port served by the last completed transaction
    logic   pick_p1_c;   // round-robin choice for a grant in IDLE

    // On a tie the port that was not served last wins.
    always_comb begin
        pick_p1_c = i_p1_req & (~i_p0_req | ~last_grant);
    end

    // Arbitration and handshake FSM; all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            o_p0_done  <= 1'b0;
            o_p1_done  <= 1'b0;
            o_p0_data  <= '0;
            o_p1_data  <= '0;
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_strb <= '0;
            o_mem_data <= '0;
            o_mem_ack  <= 1'b0;
`ifdef MEM_ARB_PERF_EN
            o_rd_count <= '0;
            o_wr_count <= '0;
`endif
        end else begin
            o_p0_done <= 1'b0;
            o_p1_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Only start while the controller handshakes are fully idle.
                    if ((i_p0_req || i_p1_req) && !i_mem_rcv && !i_mem_done) begin
                        grant      <= pick_p1_c;
                        o_mem_we   <= pick_p1_c ? i_p1_we   : i_p0_we;
                        o_mem_addr <= pick_p1_c ? i_p1_addr : i_p0_addr;
                        o_mem_strb <= pick_p1_c ? i_p1_strb : i_p0_strb;
                        o_mem_data <= pick_p1_c ? i_p1_data : i_p0_data;
                        o_mem_en   <= 1'b1;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i_mem_rcv) begin
                        o_mem_en <= 1'b0;
                        state    <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!i_mem_rcv) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    // done is level-held, so an early done is still seen here.
                    if (i_mem_done) begin
                        if (!o_mem_we) begin
                            if (grant) o_p1_data <= i_mem_data;
                            else       o_p0_data <= i_mem_data;
                        end
                        o_mem_ack <= 1'b1;
                        state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!i_mem_done) begin
                        o_mem_ack <= 1'b0;
                        o_p0_done <= ~grant;
                        o_p1_done <= grant;
                        state     <= S_COMPLETE;
                    end
                end
                S_COMPLETE: begin
                    last_grant <= grant;
`ifdef MEM_ARB_PERF_EN
                    if (o_mem_we) o_wr_count <= o_wr_count + PERF_WIDTH'(1);
                    else          o_rd_count <= o_rd_count + PERF_WIDTH'(1);
`endif
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_request_arbiter.sv
// Self-checking bench for memory_request_arbiter: table-driven transactions
// against a scripted controller, plus hand-written blocked-grant and
// reset-during-ACK sequences.
`timescale 1ns/1ps

module tb_memory_request_arbiter;

    localparam int unsigned AW = 23;
    localparam int unsigned DW = 128;
    localparam int unsigned SW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [SW-1:0] p0_strb, p1_strb;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_done, p1_done;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_en, mem_we, mem_rcv, mem_done, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_strb;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   rd_count, wr_count;
    int            exp_rd = 0;
    int            exp_wr = 0;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_p0_data = '0;
    logic [DW-1:0] exp_p1_data = '0;

    always #5 clk = ~clk;

    memory_request_arbiter dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_p0_req   (p0_req),
        .i_p0_we    (p0_we),
        .i_p0_addr  (p0_addr),
        .i_p0_strb  (p0_strb),
        .i_p0_data  (p0_wdata),
        .o_p0_done  (p0_done),
        .o_p0_data  (p0_rdata),
        .i_p1_req   (p1_req),
        .i_p1_we    (p1_we),
        .i_p1_addr  (p1_addr),
        .i_p1_strb  (p1_strb),
        .i_p1_data  (p1_wdata),
        .o_p1_done  (p1_done),
        .o_p1_data  (p1_rdata),
        .o_mem_en   (mem_en),
        .o_mem_we   (mem_we),
        .o_mem_addr (mem_addr),
        .o_mem_strb (mem_strb),
        .o_mem_data (mem_wdata),
        .i_mem_rcv  (mem_rcv),
        .i_mem_done (mem_done),
        .i_mem_data (mem_rdata),
        .o_mem_ack  (mem_ack)
`ifdef MEM_ARB_PERF_EN
        , .o_rd_count (rd_count)
        , .o_wr_count (wr_count)
`endif
    );

    typedef struct {
        logic          p0_req;
        logic          p0_we;
        logic [AW-1:0] p0_addr;
        logic [SW-1:0] p0_strb;
        logic [DW-1:0] p0_data;
        logic          p1_req;
        logic          p1_we;
        logic [AW-1:0] p1_addr;
        logic [SW-1:0] p1_strb;
        logic [DW-1:0] p1_data;
        logic [DW-1:0] rd_first;   // line returned for the first grant
        logic [DW-1:0] rd_second;  // line returned for the second grant
        bit            early;      // controller raises done before rcv falls
        int            first;      // port expected to be granted first
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_en(input logic v, input string name);
        int n = 0;
        while (mem_en !== v && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, DW'(mem_en), DW'(v));
    endtask

    task automatic wait_ack(input logic v, input string name);
        int n = 0;
        while (mem_ack !== v && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, DW'(mem_ack), DW'(v));
    endtask

    // Scripted controller for one transaction; checks payload, handshakes,
    // done pulses and the per-port read lines.
    task automatic serve(input int port, input logic we, input logic [AW-1:0] addr,
                         input logic [SW-1:0] strb, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input bit early);
        int d0 = 0;
        int d1 = 0;
        wait_en(1'b1, "mem_en_rise");
        chk("mem_we",   DW'(mem_we),   DW'(we));
        chk("mem_addr", DW'(mem_addr), DW'(addr));
        chk("mem_strb", DW'(mem_strb), DW'(strb));
        chk("mem_data", mem_wdata, wdata);
        mem_rcv = 1'b1;
        wait_en(1'b0, "mem_en_fall");
        if (early) begin
            mem_rdata = rdata;
            mem_done  = 1'b1;
            repeat (2) @(negedge clk);
            chk("ack_held_off_while_rcv", DW'(mem_ack), DW'(0));
            mem_rcv = 1'b0;
        end else begin
            mem_rcv = 1'b0;
            @(negedge clk);
            mem_rdata = rdata;
            mem_done  = 1'b1;
        end
        wait_ack(1'b1, "ack_rise");
        @(negedge clk);
        chk("ack_hold", DW'(mem_ack), DW'(1));
        mem_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (p0_done) begin d0++; p0_req = 1'b0; end
            if (p1_done) begin d1++; p1_req = 1'b0; end
        end
        chk("p0_done_pulses", DW'(d0), DW'(port == 0));
        chk("p1_done_pulses", DW'(d1), DW'(port == 1));
        chk("ack_low", DW'(mem_ack), DW'(0));
        if (!we) begin
            if (port == 0) exp_p0_data = rdata;
            else           exp_p1_data = rdata;
        end
        chk("p0_data", p0_rdata, exp_p0_data);
        chk("p1_data", p1_rdata, exp_p1_data);
`ifdef MEM_ARB_PERF_EN
        if (we) exp_wr++;
        else    exp_rd++;
`endif
    endtask

    task automatic serve_port(input vec_t v, input int port, input logic [DW-1:0] rdata);
        if (port == 0) serve(0, v.p0_we, v.p0_addr, v.p0_strb, v.p0_data, rdata, v.early);
        else           serve(1, v.p1_we, v.p1_addr, v.p1_strb, v.p1_data, rdata, v.early);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"},   DW'(mem_en),   '0);
        chk({tag, "_mem_we"},   DW'(mem_we),   '0);
        chk({tag, "_mem_addr"}, DW'(mem_addr), '0);
        chk({tag, "_mem_strb"}, DW'(mem_strb), '0);
        chk({tag, "_mem_data"}, mem_wdata,     '0);
        chk({tag, "_mem_ack"},  DW'(mem_ack),  '0);
        chk({tag, "_p0_done"},  DW'(p0_done),  '0);
        chk({tag, "_p1_done"},  DW'(p1_done),  '0);
        chk({tag, "_p0_data"},  p0_rdata,      '0);
        chk({tag, "_p1_data"},  p1_rdata,      '0);
`ifdef MEM_ARB_PERF_EN
        chk({tag, "_rd_count"}, DW'(rd_count), '0);
        chk({tag, "_wr_count"}, DW'(wr_count), '0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 23'h000010, 16'hFFFF, 128'h0,
                    1'b0, 1'b0, 23'h0, 16'h0, 128'h0,
                    128'hDEADBEEF_00000000_00000000_00000001, 128'h0, 1'b0, 0};
        vecs[1] = '{1'b0, 1'b0, 23'h0, 16'h0, 128'h0,
                    1'b1, 1'b1, 23'h000200, 16'hFFFF, {16{8'hA5}},
                    128'h1111_2222, 128'h0, 1'b0, 1};
        vecs[2] = '{1'b1, 1'b0, 23'h000030, 16'h000F, 128'h0,
                    1'b1, 1'b0, 23'h7FFFFF, 16'hF000, 128'h0,
                    {4{32'hAAAA5555}}, {4{32'hBBBB6666}}, 1'b0, 0};
        vecs[3] = '{1'b1, 1'b1, 23'h000040, 16'h00FF, {8{16'h1234}},
                    1'b1, 1'b0, 23'h000050, 16'h0000, 128'h0,
                    128'h99, {4{32'hC0FFEE00}}, 1'b0, 0};
        vecs[4] = '{1'b1, 1'b1, 23'h000060, 16'hF0F0, {4{32'h0BADF00D}},
                    1'b0, 1'b0, 23'h0, 16'h0, 128'h0,
                    128'h77, 128'h0, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b0, 23'h000070, 16'hFFFF, 128'h0,
                    1'b1, 1'b0, 23'h000080, 16'hFFFF, 128'h0,
                    {4{32'h13579BDF}}, {4{32'h2468ACE0}}, 1'b0, 1};
        vecs[6] = '{1'b0, 1'b0, 23'h0, 16'h0, 128'h0,
                    1'b1, 1'b0, 23'h000090, 16'h0F0F, 128'h0,
                    {4{32'hFEEDFACE}}, 128'h0, 1'b1, 1};
        vecs[7] = '{1'b1, 1'b0, 23'h0000A0, 16'h3C3C, 128'h0,
                    1'b0, 1'b0, 23'h0, 16'h0, 128'h0,
                    {4{32'h31415926}}, 128'h0, 1'b1, 0};

        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_strb = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_strb = '0; p1_wdata = '0;
        mem_rcv = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            p0_req = vecs[i].p0_req; p0_we = vecs[i].p0_we; p0_addr = vecs[i].p0_addr;
            p0_strb = vecs[i].p0_strb; p0_wdata = vecs[i].p0_data;
            p1_req = vecs[i].p1_req; p1_we = vecs[i].p1_we; p1_addr = vecs[i].p1_addr;
            p1_strb = vecs[i].p1_strb; p1_wdata = vecs[i].p1_data;
            serve_port(vecs[i], vecs[i].first, vecs[i].rd_first);
            if (vecs[i].p0_req && vecs[i].p1_req)
                serve_port(vecs[i], 1 - vecs[i].first, vecs[i].rd_second);
            repeat (2) @(negedge clk);
        end

        // No grant while the controller still shows done or rcv.
        mem_done = 1'b1;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 23'h0000B0; p0_strb = 16'h1; p0_wdata = '0;
        p1_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_grant_while_done", DW'(mem_en), DW'(0));
        mem_done = 1'b0;
        mem_rcv  = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_grant_while_rcv", DW'(mem_en), DW'(0));
        mem_rcv = 1'b0;
        serve(0, 1'b0, 23'h0000B0, 16'h1, '0, {4{32'h0000CAFE}}, 1'b0);
        repeat (2) @(negedge clk);

        // Reset asserted during ACK aborts everything at once.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 23'h0000C0; p0_strb = 16'hFFFF;
        wait_en(1'b1, "rst_seq_en_rise");
        mem_rcv = 1'b1;
        wait_en(1'b0, "rst_seq_en_fall");
        mem_rcv = 1'b0;
        mem_rdata = {4{32'h5A5A5A5A}};
        mem_done = 1'b1;
        wait_ack(1'b1, "rst_seq_ack_rise");
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        mem_done = 1'b0;
        p0_req = 1'b0;
        exp_p0_data = '0;
        exp_p1_data = '0;
`ifdef MEM_ARB_PERF_EN
        exp_rd = 0;
        exp_wr = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests out of reset: port 0 first, then port 1.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 23'h000010; p0_strb = 16'hFFFF; p0_wdata = '0;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 23'h000020; p1_strb = 16'h00F0; p1_wdata = {16{8'h3C}};
        serve(0, 1'b0, 23'h000010, 16'hFFFF, '0, {4{32'h87654321}}, 1'b0);
        serve(1, 1'b1, 23'h000020, 16'h00F0, {16{8'h3C}}, 128'h0, 1'b0);
        repeat (2) @(negedge clk);

`ifdef MEM_ARB_PERF_EN
        chk("rd_count", DW'(rd_count), DW'(exp_rd));
        chk("wr_count", DW'(wr_count), DW'(exp_wr));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
